// File: rtl/stopwatch_if.sv
// Handshake bundle between the stopwatch engine and its surroundings:
// tick enables and button levels in, BCD digits and status out.
`default_nettype none

interface stopwatch_if #(
  parameter int TOT_W = 13
);
  logic             i_tick;
  logic             i_adj_tick;
  logic             i_btn_reset;
  logic             i_btn_pause;
  logic             i_adj;
  logic             i_sel;
  logic [3:0]       o_min_tens;
  logic [3:0]       o_min_ones;
  logic [3:0]       o_sec_tens;
  logic [3:0]       o_sec_ones;
  logic [TOT_W-1:0] o_total_sec;
  logic             o_running;
  logic             o_adjusting;
  logic             o_at_max;

  modport master (
    output i_tick, i_adj_tick, i_btn_reset, i_btn_pause, i_adj, i_sel,
    input  o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_total_sec,
    input  o_running, o_adjusting, o_at_max
  );

  modport slave (
    input  i_tick, i_adj_tick, i_btn_reset, i_btn_pause, i_adj, i_sel,
    output o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_total_sec,
    output o_running, o_adjusting, o_at_max
  );
endinterface

`default_nettype wire

// File: rtl/stopwatch_core.sv
// ---------------------------------------------------------------------------
// stopwatch_core : MM:SS BCD stopwatch with run/pause/adjust state machine
// Revision 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module stopwatch_core #(
  parameter int MAX_MIN = 99,
  parameter int WRAP    = 0,
  parameter int TOT_W   = 13
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  stopwatch_if.slave  sw
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ADJ   = 2'd3
  } state_t;

  localparam logic [3:0]       c_MAX_T    = 4'(MAX_MIN / 10);
  localparam logic [3:0]       c_MAX_O    = 4'(MAX_MIN % 10);
  localparam logic [TOT_W-1:0] c_MIN_SPAN = TOT_W'(MAX_MIN * 60);
  localparam logic [TOT_W-1:0] c_SIXTY    = TOT_W'(60);
  localparam logic [TOT_W-1:0] c_SEC_SPAN = TOT_W'(59);
  localparam logic [TOT_W-1:0] c_ONE      = TOT_W'(1);

  state_t           r_state;
  logic [3:0]       r_min_t, r_min_o, r_sec_t, r_sec_o;
  logic [TOT_W-1:0] r_total;
  logic             r_reset_q, r_pause_q;
  logic             r_running, r_adjusting;

  logic             w_rst_edge, w_pause_edge;
  logic             w_sec_max, w_min_max, w_at_max;
  logic [3:0]       w_sec_t_inc, w_sec_o_inc, w_min_t_inc, w_min_o_inc;

  assign w_rst_edge   = sw.i_btn_reset & ~r_reset_q;
  assign w_pause_edge = sw.i_btn_pause & ~r_pause_q;

  assign w_sec_max = (r_sec_t == 4'd5) && (r_sec_o == 4'd9);
  assign w_min_max = (r_min_t == c_MAX_T) && (r_min_o == c_MAX_O);
  assign w_at_max  = w_sec_max & w_min_max;

  // Field increments wrap on their own; the minute carry is applied only in RUN.
  assign w_sec_o_inc = (r_sec_o == 4'd9) ? 4'd0 : r_sec_o + 4'd1;
  assign w_sec_t_inc = w_sec_max ? 4'd0 :
                       (r_sec_o == 4'd9) ? r_sec_t + 4'd1 : r_sec_t;
  assign w_min_o_inc = w_min_max ? 4'd0 :
                       (r_min_o == 4'd9) ? 4'd0 : r_min_o + 4'd1;
  assign w_min_t_inc = w_min_max ? 4'd0 :
                       (r_min_o == 4'd9) ? r_min_t + 4'd1 : r_min_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_STOP;
      r_min_t     <= 4'd0;
      r_min_o     <= 4'd0;
      r_sec_t     <= 4'd0;
      r_sec_o     <= 4'd0;
      r_total     <= '0;
      r_reset_q   <= 1'b0;
      r_pause_q   <= 1'b0;
      r_running   <= 1'b0;
      r_adjusting <= 1'b0;
    end else begin
      r_reset_q <= sw.i_btn_reset;
      r_pause_q <= sw.i_btn_pause;

      if (w_rst_edge) begin
        r_min_t     <= 4'd0;
        r_min_o     <= 4'd0;
        r_sec_t     <= 4'd0;
        r_sec_o     <= 4'd0;
        r_total     <= '0;
        r_running   <= 1'b0;
        r_adjusting <= sw.i_adj;
        r_state     <= sw.i_adj ? ST_ADJ : ST_STOP;
      end else if (sw.i_adj) begin
        if (r_state != ST_ADJ) begin
          r_state     <= ST_ADJ;
          r_running   <= 1'b0;
          r_adjusting <= 1'b1;
        end else if (sw.i_adj_tick) begin
          if (sw.i_sel) begin
            r_min_t <= w_min_t_inc;
            r_min_o <= w_min_o_inc;
            r_total <= w_min_max ? r_total - c_MIN_SPAN : r_total + c_SIXTY;
          end else begin
            r_sec_t <= w_sec_t_inc;
            r_sec_o <= w_sec_o_inc;
            r_total <= w_sec_max ? r_total - c_SEC_SPAN : r_total + c_ONE;
          end
        end
      end else if (r_state == ST_ADJ) begin
        r_state     <= ST_PAUSE;
        r_adjusting <= 1'b0;
      end else if (w_pause_edge) begin
        if (r_state == ST_RUN) begin
          r_state   <= ST_PAUSE;
          r_running <= 1'b0;
        end else begin
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
      end else if ((r_state == ST_RUN) && sw.i_tick) begin
        if (w_at_max) begin
          // Saturating builds simply hold; wrapping builds restart from zero.
          if (WRAP != 0) begin
            r_min_t <= 4'd0;
            r_min_o <= 4'd0;
            r_sec_t <= 4'd0;
            r_sec_o <= 4'd0;
            r_total <= '0;
          end
        end else begin
          r_sec_t <= w_sec_t_inc;
          r_sec_o <= w_sec_o_inc;
          r_total <= r_total + c_ONE;
          if (w_sec_max) begin
            r_min_t <= w_min_t_inc;
            r_min_o <= w_min_o_inc;
          end
        end
      end
    end
  end

  assign sw.o_min_tens  = r_min_t;
  assign sw.o_min_ones  = r_min_o;
  assign sw.o_sec_tens  = r_sec_t;
  assign sw.o_sec_ones  = r_sec_o;
  assign sw.o_total_sec = r_total;
  assign sw.o_running   = r_running;
  assign sw.o_adjusting = r_adjusting;
  assign sw.o_at_max    = w_at_max;

endmodule

`default_nettype wire
